// File: rtl/accumulator_control_unit.sv
// Multicycle fetch/decode/execute controller for the 16-bit accumulator datapath.
// Drives ROM address, datapath mux selects, ALU op and write strobes.
module accumulator_control_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int ADDRRAM_WIDTH = 10,
  parameter int OPCODE_WIDTH  = 5,
  parameter int SEL_OPERATION = 3,
  parameter int SEL_WIDTH     = 2
) (
  input  logic                     clock_i,
  input  logic                     nreset_i,
  input  logic [DATA_WIDTH-1:0]    im_data_i,
  input  logic                     n_i,
  input  logic                     z_i,
  input  logic [ADDRRAM_WIDTH-1:0] ext2pc_i,
  output logic [ADDRRAM_WIDTH-1:0] im_addr_o,
  output logic [SEL_WIDTH-1:0]     selA_o,
  output logic                     selB_o,
  output logic                     wrAccA_o,
  output logic [SEL_OPERATION-1:0] op_o,
  output logic [OPERAND_WIDTH-1:0] operand_o,
  output logic                     dm_wr_o,
  output logic                     halt_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OPC_HLT = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STO = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LD  = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LDI = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JMP = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BEQ = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BLT = 5'b00110;

  state_t                     state, state_nxt;
  logic [ADDRRAM_WIDTH-1:0]   pc, pc_nxt;
  logic [DATA_WIDTH-1:0]      ir;
  logic [OPCODE_WIDTH-1:0]    opcode;
  logic [OPCODE_WIDTH-1:0]    fetch_opcode;
  logic                       branch_taken;

  assign opcode       = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign fetch_opcode = im_data_i[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand_o    = ir[OPERAND_WIDTH-1:0];
  assign im_addr_o    = pc;
  assign halt_o       = (state == S_HALT);

  // Memory-operand instructions need one extra cycle for the synchronous data-memory read.
  function automatic logic needs_mem(input logic [OPCODE_WIDTH-1:0] opc);
    return (opc[OPCODE_WIDTH-1] && !opc[0]) || (opc == OPC_LD);
  endfunction

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_DECODE) ir <= im_data_i;
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    unique case (opcode)
      OPC_JMP: branch_taken = 1'b1;
      OPC_BEQ: branch_taken = z_i;
      OPC_BLT: branch_taken = n_i;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        pc_nxt = pc + ADDRRAM_WIDTH'(1);
        if (fetch_opcode == OPC_HLT)  state_nxt = S_HALT;
        else if (needs_mem(fetch_opcode)) state_nxt = S_MEM;
        else                          state_nxt = S_EXEC;
      end
      S_MEM:    state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (branch_taken) pc_nxt = ext2pc_i;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Selects are held through MEM so the datapath sees them settled before the EXEC write.
  always_comb begin
    selA_o   = '0;
    selB_o   = 1'b0;
    op_o     = '0;
    wrAccA_o = 1'b0;
    dm_wr_o  = 1'b0;
    if (state == S_MEM || state == S_EXEC) begin
      if (opcode[OPCODE_WIDTH-1]) begin
        op_o   = opcode[3:1];
        selB_o = opcode[0];
        selA_o = 2'b10;
      end else if (opcode == OPC_LDI) begin
        selA_o = 2'b01;
      end
      if (state == S_EXEC) begin
        wrAccA_o = opcode[OPCODE_WIDTH-1] || (opcode == OPC_LD) || (opcode == OPC_LDI);
        dm_wr_o  = (opcode == OPC_STO);
      end
    end
  end

endmodule

// File: doc/accumulator_control_unit.md
# accumulator_control_unit

Multicycle control unit for the 16-bit accumulator datapath. It fetches 16-bit instructions from a synchronous instruction ROM and holds a 10-bit PC and an instruction register. It decodes a 5-bit opcode and drives the datapath mux selects, accumulator write enable, ALU operation, data-memory write strobe and 11-bit operand field. Conditional branches use the datapath's registered n/z flags.

## Interface
- DATA_WIDTH, 16, instruction width
- OPERAND_WIDTH, 11, operand field ir[10:0]
- ADDRRAM_WIDTH, 10, PC / instruction address width
- OPCODE_WIDTH, 5, opcode field ir[15:11]
- SEL_OPERATION, 3, ALU select width
- SEL_WIDTH, 2, accumulator-input mux select width

Ports:
- clock_i  in  1  system clock; all state changes on its rising edge
- nreset_i  in  1  reset, asynchronous, active-low
- im_data_i  in  16  instruction ROM data, valid one cycle after im_addr_o
- n_i  in  1  datapath negative flag
- z_i  in  1  datapath zero flag
- ext2pc_i  in  10  datapath branch target (extended operand [9:0])
- im_addr_o  out  10  instruction address (= PC)
- selA_o  out  2  accumulator input: 00 data memory, 01 immediate, 10 ALU
- selB_o  out  1  ALU operand B: 0 data memory, 1 immediate
- wrAccA_o  out  1  accumulator load enable
- op_o  out  3  ALU operation
- operand_o  out  11  ir[10:0], also the data-memory address
- dm_wr_o  out  1  data-memory write strobe (writes accumulator)
- halt_o  out  1  processor halted

## Operation
- States: FETCH, DECODE, MEM, EXEC, HALT.
- FETCH: im_addr_o = pc → DECODE.
- DECODE: ir <= im_data_i; pc <= pc+1, mod 1024, so 1023 wraps to 0.
  - Memory-read instructions → MEM; HLT → HALT; all others → EXEC.
- MEM: one wait cycle for synchronous data-memory read → EXEC.
- EXEC: asserts the instruction's controls for exactly one cycle → FETCH.
- HALT: absorbing state; halt_o=1; only nreset_i leaves it.
- Decode, by ir[15:11]. Controls are inactive (0) except where listed.
  - 1xxxx ALU: op_o=opcode[3:1]; selB_o=opcode[0] (1 = immediate); selA_o=10; wrAccA_o=1 in EXEC. Goes via MEM when opcode[0]=0.
  - 00000 HLT.
  - 00001 STO: dm_wr_o=1 in EXEC; no MEM.
  - 00010 LD: via MEM; selA_o=00; wrAccA_o=1.
  - 00011 LDI: selA_o=01; wrAccA_o=1.
  - 00100 JMP: pc <= ext2pc_i.
  - 00101 BEQ: pc <= ext2pc_i if z_i=1.
  - 00110 BLT: pc <= ext2pc_i if n_i=1.
  - 00111 NOP.
  - 01xxx reserved: executed as NOP, never halts.
- A branch overrides the DECODE increment; a not-taken branch keeps pc+1.
- operand_o = ir[10:0] combinationally in all states. It is stable through MEM and EXEC.
- selA_o, selB_o and op_o hold their decoded values in MEM and EXEC and are 0 elsewhere. wrAccA_o and dm_wr_o are high only in EXEC.

## Timing
- Reset (asynchronous, any state): state=FETCH, pc=0, ir=0, halt_o=0, every control output 0, operand_o=0, im_addr_o=0. The first fetch is from address 0 on the first edge after release.
- Latency:
  - 3 cycles: immediate ALU, LDI, STO, branches, NOP.
  - 4 cycles: LD and memory-operand ALU.
  - HLT: 2 cycles to HALT.
- Flags are registered by the datapath one edge after the accumulator updates. The shortest path from an accumulator write to the next branch's EXEC is 3 edges (FETCH, DECODE, EXEC), so the flags are always current; no interlock is required.
- n_i, z_i and ext2pc_i are sampled only on the EXEC edge.
- Reset asserted during EXEC suppresses any pending PC or accumulator update from the controller side.

## Test plan
- Reset: hold nreset_i low for 3 cycles → all outputs 0, im_addr_o=0. Release → im_addr_o=0 in FETCH, then 1 after DECODE.
- LDI 5, ALU-immediate add (opcode 10001, imm 3), STO 0x010:
  - wrAccA_o pulses on cycles 3 and 6; first with selA_o=01, second with selA_o=10, selB_o=1, op_o=000.
  - dm_wr_o pulses once on cycle 9 with operand_o=0x010.
- LD 0x020, then ALU-memory add (opcode 10000): each takes 4 cycles; MEM precedes EXEC; wrAccA_o is 0 in MEM; selB_o=0 in EXEC.
- BEQ 0x100:
  - z_i=1 → next im_addr_o=0x100.
  - z_i=0 → next im_addr_o=pc+1.
  - BLT with n_i=1/0 behaves the same way.
- Place a NOP at 1023 (reached via JMP 0x3FF) → next fetch address is 0. A reserved opcode 01010 behaves as NOP.
- HLT → halt_o=1, outputs stay static for 20 cycles. Asynchronous reset mid-EXEC of an LDI → wrAccA_o drops immediately, halt_o=0, PC restarts at 0.
